// File: rtl/mux_nway_pkg.sv
// Shared definitions for the N-way pipelined word multiplexer: mode encoding,
// channel-count bound and the round-robin grant search.
package mux_nway_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int MAX_NUM_IN = 16;
  localparam int MAX_IDX_W  = 4;

  // One-hot grant for the first set request at or above ptr, wrapping at n-1.
  function automatic logic [MAX_NUM_IN-1:0] rr_next_grant(
    input logic [MAX_NUM_IN-1:0] req,
    input int                    ptr,
    input int                    n
  );
    logic [MAX_NUM_IN-1:0] grant;
    logic                  found;
    int                    idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NUM_IN; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[MAX_IDX_W-1:0]]) begin
        grant[idx[MAX_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mux_nway_pipe_rr_arbiter.sv
// Round-robin arbiter: grants the first requester from the pointer upward and
// advances the pointer past the winner whenever the grant is used.
module rr_arbiter
  import mux_nway_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_IN-1:0] i_req,
  input  logic              i_advance,
  output logic [NUM_IN-1:0] o_grant,
  output logic [SEL_W-1:0]  o_grant_idx,
  output logic              o_has_grant
);

  logic [SEL_W-1:0]      r_ptr;
  logic [MAX_NUM_IN-1:0] w_req_ext;
  logic [MAX_NUM_IN-1:0] w_grant_ext;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_IN-1:0]  = i_req;
    w_grant_ext            = rr_next_grant(w_req_ext, int'(r_ptr), NUM_IN);
    o_grant                = w_grant_ext[NUM_IN-1:0];
    o_has_grant            = |w_grant_ext;
    o_grant_idx            = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (o_grant[i]) o_grant_idx = SEL_W'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_has_grant) begin
      r_ptr <= (o_grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : o_grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_nway_pipe.sv
// N-input word mux with registered output, valid/ready on every channel, fixed
// or round-robin selection. Define MUX_NWAY_SKID_EN to add a one-entry skid buffer.
module mux_nway_pipe
  import mux_nway_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_IN*WIDTH-1:0] In_Data,
  input  logic [NUM_IN-1:0]       In_Valid,
  output logic [NUM_IN-1:0]       In_Ready,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    Mode_RR,
  output logic [WIDTH-1:0]        Out_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [SEL_W-1:0]        Out_Src,
  output logic                    Sel_Err
);

  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_src;
  logic              r_sel_err;

  logic              w_rr;
  logic              w_sel_oor;
  logic              w_accept_en;
  logic              w_xfer;
  logic              w_has_grant;
  logic [NUM_IN-1:0] w_fix_req;
  logic [NUM_IN-1:0] w_grant;
  logic [NUM_IN-1:0] w_ready;
  logic [NUM_IN-1:0] w_xfer_vec;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [SEL_W-1:0]  w_src;
  logic [WIDTH-1:0]  w_data;

  assign w_rr      = (mode_e'(Mode_RR) == MODE_RR);
  assign w_sel_oor = ({1'b0, Sel} >= NUM_IN_L);

`ifdef MUX_NWAY_SKID_EN
  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_skid_src;
  logic             r_skid_valid;

  // Readiness depends only on skid occupancy, never on Out_Ready.
  assign w_accept_en = !r_skid_valid;
`else
  assign w_accept_en = !r_out_valid || Out_Ready;
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_rr_arbiter (
    .i_clk       (Clk),
    .i_rst       (Rst),
    .i_req       (In_Valid),
    .i_advance   (w_rr && w_xfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_has_grant (w_has_grant)
  );

  always_comb begin
    w_fix_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_fix_req[i] = !w_sel_oor && (Sel == SEL_W'(i));
    end
  end

  always_comb begin
    w_ready = '0;
    if (!Rst && w_accept_en) begin
      w_ready = w_rr ? (w_has_grant ? w_grant : '0) : w_fix_req;
    end
    w_xfer_vec = In_Valid & w_ready;
    w_xfer     = |w_xfer_vec;
    w_src      = w_rr ? w_grant_idx : Sel;
    w_data     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_xfer_vec[i]) w_data = In_Data[i*WIDTH +: WIDTH];
    end
  end

`ifdef MUX_NWAY_SKID_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_src    <= '0;
      r_sel_err    <= 1'b0;
      r_skid_data  <= '0;
      r_skid_src   <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_sel_err <= !w_rr && w_sel_oor && w_accept_en;
      // A full skid blocks all inputs, so it only ever drains here.
      if (r_skid_valid) begin
        if (Out_Ready) begin
          r_out_data   <= r_skid_data;
          r_out_src    <= r_skid_src;
          r_skid_valid <= 1'b0;
        end
      end else if (w_xfer) begin
        if (!r_out_valid || Out_Ready) begin
          r_out_data  <= w_data;
          r_out_src   <= w_src;
          r_out_valid <= 1'b1;
        end else begin
          r_skid_data  <= w_data;
          r_skid_src   <= w_src;
          r_skid_valid <= 1'b1;
        end
      end else if (Out_Ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sel_err <= !w_rr && w_sel_oor && w_accept_en;
      if (w_xfer) begin
        r_out_data  <= w_data;
        r_out_src   <= w_src;
        r_out_valid <= 1'b1;
      end else if (Out_Ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`endif

  assign In_Ready  = w_ready;
  assign Out_Data  = r_out_data;
  assign Out_Valid = r_out_valid;
  assign Out_Src   = r_out_src;
  assign Sel_Err   = r_sel_err;

endmodule

// File: tb/tb_mux_nway_pipe.sv
// Bench for mux_nway_pipe: a 4-channel instance with an output scoreboard and
// a 3-channel instance for out-of-range select behaviour.
module tb_mux_nway_pipe;

  localparam int W  = 32;
  localparam int N4 = 4;
  localparam int S4 = 2;
  localparam int N3 = 3;
  localparam int S3 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [N4*W-1:0] in_data;
  logic [N4-1:0]   in_valid, in_ready;
  logic [S4-1:0]   sel, out_src;
  logic            mode, out_valid, out_ready, sel_err;
  logic [W-1:0]    out_data;

  logic [N3*W-1:0] in_data3;
  logic [N3-1:0]   in_valid3, in_ready3;
  logic [S3-1:0]   sel3, out_src3;
  logic            mode3, out_valid3, out_ready3, sel_err3;
  logic [W-1:0]    out_data3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [S4+W-1:0] exp_q[$];

  mux_nway_pipe #(.WIDTH(W), .NUM_IN(N4)) u_dut4 (
    .Clk(clk), .Rst(rst), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
    .Sel(sel), .Mode_RR(mode), .Out_Data(out_data), .Out_Valid(out_valid),
    .Out_Ready(out_ready), .Out_Src(out_src), .Sel_Err(sel_err)
  );

  mux_nway_pipe #(.WIDTH(W), .NUM_IN(N3)) u_dut3 (
    .Clk(clk), .Rst(rst), .In_Data(in_data3), .In_Valid(in_valid3), .In_Ready(in_ready3),
    .Sel(sel3), .Mode_RR(mode3), .Out_Data(out_data3), .Out_Valid(out_valid3),
    .Out_Ready(out_ready3), .Out_Src(out_src3), .Sel_Err(sel_err3)
  );

  // Output monitor: every consumed word must match the oldest expected word.
  always @(negedge clk) begin
    logic [S4+W-1:0] exp_w;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got src=%0d data=%h, required no word", out_src, out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({out_src, out_data} !== exp_w) begin
          n_fail++;
          $display("FAIL sb_word: got src=%0d data=%h, required src=%0d data=%h",
                   out_src, out_data, exp_w[S4+W-1:W], exp_w[W-1:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '1; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '1; out_ready3 = 1'b1;
    step(); step();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b, required 0000/000", in_ready, in_ready3);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b d=%h s=%0d e=%b, required all 0", out_valid, out_data, out_src, sel_err);
    end
    step();
    rst = 1'b0; sel = 2'd2; in_data[2*W +: W] = 32'hDEADBEEF; in_valid = 4'b0100; in_valid3 = '0;
    exp_q.push_back({2'd2, 32'hDEADBEEF});
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL first_ready: got %b, required 0100", in_ready);
    end
    step();
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 2'd2) begin
      n_fail++;
      $display("FAIL first_word: got v=%b d=%h s=%0d, required v=1 d=deadbeef s=2", out_valid, out_data, out_src);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_drain: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    step();
    mode = 1'b0; sel = 2'd1; out_ready = 1'b1; in_valid = 4'b0010; in_data[W +: W] = 32'h11;
    exp_q.push_back({2'd1, 32'h11});
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_ready0: got %b, required 0010", in_ready);
    end
    step();
    in_data[W +: W] = 32'h22;
    exp_q.push_back({2'd1, 32'h22});
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0010 || out_data !== 32'h11) begin
      n_fail++; $display("FAIL bp_ready1: got ready=%b data=%h, required 0010 11", in_ready, out_data);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) begin
        in_data[W +: W] = 32'h33;
        exp_q.push_back({2'd1, 32'h33});
      end
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready[1] !== 1'b0 || out_data !== 32'h22 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got ready=%b data=%h v=%b, required 0 22 1", k, in_ready[1], out_data, out_valid);
      end
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_resume: got %b, required 0010", in_ready);
    end
    step();
    in_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_done: got v=%b pending=%0d, required 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_rr_fairness();
    logic [S4-1:0] exp_src;
    step();
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N4; i++) in_data[i*W +: W] = 32'hA000_0000 + 32'(i);
    in_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      exp_src = S4'(k % 4);
      exp_q.push_back({exp_src, 32'hA000_0000 + 32'(k % 4)});
      @(negedge clk);
      n_checks++;
      if (in_ready !== (4'b0001 << exp_src)) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b, required %b", k, in_ready, 4'b0001 << exp_src);
      end
      if (k > 0) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rr_rate%0d: got valid=%b, required 1", k, out_valid);
        end
      end
    end
    step();
    in_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rr_done: got v=%b pending=%0d, required 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_sparse_rr();
    logic [S4-1:0] exp_src;
    step();
    rst = 1'b1; in_valid = '0; mode = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
    in_data[W +: W] = 32'hB1; in_data[3*W +: W] = 32'hB3; in_valid = 4'b0010;
    exp_q.push_back({2'd1, 32'hB1});
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL sp_prime: got %b, required 0010", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      in_valid = 4'b1010;
      exp_src = (k % 2 == 0) ? 2'd3 : 2'd1;
      exp_q.push_back({exp_src, (exp_src == 2'd3) ? 32'hB3 : 32'hB1});
      @(negedge clk);
      n_checks++;
      if (in_ready !== (4'b0001 << exp_src)) begin
        n_fail++; $display("FAIL sp_grant%0d: got %b, required %b", k, in_ready, 4'b0001 << exp_src);
      end
    end
    step();
    in_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL sp_done: got v=%b pending=%0d, required 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_sel_oor();
    step();
    mode3 = 1'b0; out_ready3 = 1'b1; sel3 = 2'd2; in_valid3 = 3'b111; in_data3[2*W +: W] = 32'hC2;
    @(negedge clk);
    n_checks++;
    if (in_ready3 !== 3'b100) begin
      n_fail++; $display("FAIL oor_inrange: got %b, required 100", in_ready3);
    end
    step();
    sel3 = 2'd3;
    @(negedge clk);
    n_checks++;
    if (in_ready3 !== 3'b000 || out_valid3 !== 1'b1 || out_src3 !== 2'd2 || out_data3 !== 32'hC2) begin
      n_fail++;
      $display("FAIL oor_block: got r=%b v=%b s=%0d d=%h, required 000 1 2 c2", in_ready3, out_valid3, out_src3, out_data3);
    end
    step();
    sel3 = 2'd0; in_valid3 = '0;
    @(negedge clk);
    n_checks++;
    if (sel_err3 !== 1'b1 || out_valid3 !== 1'b0) begin
      n_fail++; $display("FAIL oor_err1: got err=%b v=%b, required 1 0", sel_err3, out_valid3);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (sel_err3 !== 1'b0) begin
      n_fail++; $display("FAIL oor_pulse: got err=%b, required 0", sel_err3);
    end
    step();
    sel3 = 2'd3; in_valid3 = 3'b111;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++;
    if (sel_err3 !== 1'b1 || in_ready3 !== 3'b000) begin
      n_fail++; $display("FAIL oor_hold: got err=%b r=%b, required 1 000", sel_err3, in_ready3);
    end
    step();
    sel3 = 2'd1; in_valid3 = '0;
    @(negedge clk);
    n_checks++;
    if (sel_err3 !== 1'b1) begin
      n_fail++; $display("FAIL oor_err2: got err=%b, required 1", sel_err3);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin
      n_fail++; $display("FAIL oor_clear: got err=%b v=%b, required 0 0", sel_err3, out_valid3);
    end
    step();
    mode3 = 1'b1; sel3 = 2'd3; in_valid3 = 3'b111; in_data3[W-1:0] = 32'hC0;
    @(negedge clk);
    n_checks++;
    if (in_ready3 !== 3'b001) begin
      n_fail++; $display("FAIL oor_rr_grant: got %b, required 001", in_ready3);
    end
    step();
    in_valid3 = '0;
    @(negedge clk);
    n_checks++;
    if (sel_err3 !== 1'b0 || out_valid3 !== 1'b1 || out_src3 !== 2'd0 || out_data3 !== 32'hC0) begin
      n_fail++;
      $display("FAIL oor_rr_out: got err=%b v=%b s=%0d d=%h, required 0 1 0 c0", sel_err3, out_valid3, out_src3, out_data3);
    end
  endtask

  task automatic test_reset_mid_stall();
    step();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100; in_data[2*W +: W] = 32'hD2;
    exp_q.push_back({2'd2, 32'hD2});
    @(negedge clk);
    step();
    in_valid = '0;
    @(negedge clk);
    step();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[W-1:0] = 32'h55; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rs_load: got %b, required 0001", in_ready);
    end
    step();
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55) begin
      n_fail++; $display("FAIL rs_stall: got v=%b d=%h, required 1 55", out_valid, out_data);
    end
    step();
    rst = 1'b1; in_valid = 4'hF;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rs_ready: got %b, required 0000", in_ready);
    end
    step();
    rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
    exp_q.push_back({2'd0, 32'h55});
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rs_after: got v=%b r=%b, required 0 0001", out_valid, in_ready);
    end
    step();
    in_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rs_done: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int       s;
    logic [W-1:0] d;
    logic     accepted;
    mode = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      s = $urandom_range(0, N4 - 1);
      d = $urandom;
      sel = S4'(s);
      in_data[s*W +: W] = d;
      in_valid = 4'b0001 << s;
      out_ready = 1'($urandom_range(0, 1));
      exp_q.push_back({S4'(s), d});
      accepted = 1'b0;
      for (int c = 0; c < 40 && !accepted; c++) begin
        if (c > 0) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (in_ready[s]) accepted = 1'b1;
      end
      n_checks++;
      if (!accepted) begin
        n_fail++; $display("FAIL b2b_timeout%0d: got no accept on ch %0d, required accept within 40 cycles", n, s);
      end
    end
    step();
    in_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: got pending=%0d v=%b, required 0 0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_rr_fairness();
    test_sparse_rr();
    test_sel_oor();
    test_reset_mid_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
